// File: rtl/uvmt_cv32e40s_obi_stall_pkg.sv
// -----------------------------------------------------------------------------
// uvmt_cv32e40s_obi_stall_pkg
// Shared constants and types for the OBI stall monitor:
//   - channel index constants for the cv32e40s instruction/data OBI ports
//   - err_sticky_o bit positions and the packed sticky-error type
//   - default limits used as parameter defaults by the monitor and channel
// No ports (package).
// -----------------------------------------------------------------------------
package uvmt_cv32e40s_obi_stall_pkg;

  // Channel indices of the cv32e40s OBI ports
  localparam int unsigned OBI_CH_INSTR = 0;
  localparam int unsigned OBI_CH_DATA  = 1;

  // Default configuration
  localparam int unsigned DEF_NUM_CH          = 2;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_MAX_RSP_STALLS  = 8;
  localparam int unsigned DEF_MAX_GNT_STALLS  = 8;
  localparam int unsigned DEF_CNT_W           = 8;

  // Bit positions inside one channel's err_sticky slice
  localparam int unsigned ERR_RSP_BIT = 0;
  localparam int unsigned ERR_GNT_BIT = 1;
  localparam int unsigned ERR_OVF_BIT = 2;
  localparam int unsigned ERR_UNF_BIT = 3;
  localparam int unsigned ERR_W       = 4;

  // Sticky error flags; field order matches the bit positions above (MSB first)
  typedef struct packed {
    logic underflow;
    logic overflow;
    logic gnt_viol;
    logic rsp_viol;
  } err_sticky_t;

endpackage : uvmt_cv32e40s_obi_stall_pkg

// File: rtl/uvmt_cv32e40s_obi_stall_monitor_channel.sv
// -----------------------------------------------------------------------------
// uvmt_cv32e40s_obi_stall_channel
// One OBI channel of the stall monitor: in-order age tracker for outstanding
// transactions, grant-stall timer, phase counters, worst-case response stall
// and violation/sticky error flags. All outputs are registered.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i, gnt_i         address phase signals
//   rvalid_i             response phase valid
//   addr_ph_cnt_o        address-phase handshakes (wraps at 2^32)
//   rsp_ph_cnt_o         response phases (wraps at 2^32)
//   outstanding_o        entries currently tracked
//   max_rsp_stalls_o     worst response stall count seen
//   rsp_viol_o           1-cycle pulse, response stall limit exceeded
//   gnt_viol_o           1-cycle pulse, grant stall limit exceeded
//   err_sticky_o         {underflow, overflow, gnt_viol, rsp_viol}
// -----------------------------------------------------------------------------
module uvmt_cv32e40s_obi_stall_channel
  import uvmt_cv32e40s_obi_stall_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned MAX_RSP_STALLS  = DEF_MAX_RSP_STALLS,
  parameter int unsigned MAX_GNT_STALLS  = DEF_MAX_GNT_STALLS,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  output logic [31:0]      addr_ph_cnt_o,
  output logic [31:0]      rsp_ph_cnt_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic [CNT_W-1:0] max_rsp_stalls_o,
  output logic             rsp_viol_o,
  output logic             gnt_viol_o,
  output logic [ERR_W-1:0] err_sticky_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] RSP_LIMIT = CNT_W'(MAX_RSP_STALLS + 1);
  localparam logic [CNT_W-1:0] GNT_LIMIT = CNT_W'(MAX_GNT_STALLS);

  // Saturating increment so old entries and long grant stalls never wrap
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // State. age_q[0] is the head (oldest); age_q[i] holds the entry's age in
  // the current cycle, so an entry handshaken at T reads k at cycle T+k.
  logic [CNT_W-1:0] age_q [MAX_OUTSTANDING];
  logic [CNT_W-1:0] age_d [MAX_OUTSTANDING];
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      addr_cnt_q, addr_cnt_d;
  logic [31:0]      rsp_cnt_q, rsp_cnt_d;
  logic [CNT_W-1:0] max_stalls_q, max_stalls_d;
  logic [CNT_W-1:0] gnt_tmr_q, gnt_tmr_d;
  logic             rsp_viol_q, rsp_viol_d;
  logic             gnt_viol_q, gnt_viol_d;
  err_sticky_t      err_q, err_d;

  // Combinational helpers
  logic             push_s, pop_s, push_ok_s;
  logic             empty_s, full_s;
  logic             overflow_s, underflow_s, gnt_stall_s;
  logic [CNT_W-1:0] head_age_s, stalls_s, kept_s;
  logic [CNT_W-1:0] age_ext_s [MAX_OUTSTANDING+1];

  // Event decode: handshake, in-order pop, overflow/underflow, grant stall
  always_comb begin
    push_s      = req_i & gnt_i;
    empty_s     = (count_q == CNT_ZERO);
    full_s      = (count_q == DEPTH_C);
    pop_s       = rvalid_i & ~empty_s;
    underflow_s = rvalid_i & empty_s;
    // A pop in the same cycle frees the slot the push needs
    overflow_s  = push_s & full_s & ~pop_s;
    push_ok_s   = push_s & ~overflow_s;
    gnt_stall_s = req_i & ~gnt_i;
    head_age_s  = age_q[0];
    // Head age is at least 1 whenever a pop is possible
    stalls_s    = head_age_s - CNT_ONE;
    if (pop_s) begin
      kept_s = count_q - CNT_ONE;
    end else begin
      kept_s = count_q;
    end
  end

  // Tracker view with a zero slot past the end, so the shift needs no bounds case
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      age_ext_s[i] = age_q[i];
    end
    age_ext_s[MAX_OUTSTANDING] = CNT_ZERO;
  end

  // Next tracker contents: shift out the head on pop, age survivors, append at tail
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      age_d[i] = CNT_ZERO;
      if (CNT_W'(i) < kept_s) begin
        if (pop_s) begin
          age_d[i] = sat_inc(age_ext_s[i+1]);
        end else begin
          age_d[i] = sat_inc(age_ext_s[i]);
        end
      end else if (push_ok_s && (CNT_W'(i) == kept_s)) begin
        // Age 0 this cycle, so 1 from the next cycle on
        age_d[i] = CNT_ONE;
      end else begin
        age_d[i] = CNT_ZERO;
      end
    end
  end

  // Next counters, grant timer, pulses and sticky flags
  always_comb begin
    count_d = count_q;
    if (push_ok_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end

    addr_cnt_d = addr_cnt_q + {31'd0, push_s};
    rsp_cnt_d  = rsp_cnt_q + {31'd0, rvalid_i};

    if (pop_s && (stalls_s > max_stalls_q)) begin
      max_stalls_d = stalls_s;
    end else begin
      max_stalls_d = max_stalls_q;
    end

    if (gnt_stall_s) begin
      gnt_tmr_d = sat_inc(gnt_tmr_q);
    end else begin
      gnt_tmr_d = CNT_ZERO;
    end

    // The head passes RSP_LIMIT exactly once, so this pulses once per transaction
    rsp_viol_d = ~empty_s & ~rvalid_i & (head_age_s == RSP_LIMIT);
    // Timer already holds MAX_GNT_STALLS prior stalls; the timer saturates past it
    gnt_viol_d = gnt_stall_s & (gnt_tmr_q == GNT_LIMIT);

    err_d.underflow = err_q.underflow | underflow_s;
    err_d.overflow  = err_q.overflow  | overflow_s;
    err_d.gnt_viol  = err_q.gnt_viol  | gnt_viol_d;
    err_d.rsp_viol  = err_q.rsp_viol  | rsp_viol_d;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        age_q[i] <= CNT_ZERO;
      end
      count_q      <= CNT_ZERO;
      addr_cnt_q   <= 32'd0;
      rsp_cnt_q    <= 32'd0;
      max_stalls_q <= CNT_ZERO;
      gnt_tmr_q    <= CNT_ZERO;
      rsp_viol_q   <= 1'b0;
      gnt_viol_q   <= 1'b0;
      err_q        <= '{1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        age_q[i] <= age_d[i];
      end
      count_q      <= count_d;
      addr_cnt_q   <= addr_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      max_stalls_q <= max_stalls_d;
      gnt_tmr_q    <= gnt_tmr_d;
      rsp_viol_q   <= rsp_viol_d;
      gnt_viol_q   <= gnt_viol_d;
      err_q        <= err_d;
    end
  end

  assign addr_ph_cnt_o    = addr_cnt_q;
  assign rsp_ph_cnt_o     = rsp_cnt_q;
  assign outstanding_o    = count_q;
  assign max_rsp_stalls_o = max_stalls_q;
  assign rsp_viol_o       = rsp_viol_q;
  assign gnt_viol_o       = gnt_viol_q;
  assign err_sticky_o     = err_q;

endmodule : uvmt_cv32e40s_obi_stall_channel

// File: rtl/uvmt_cv32e40s_obi_stall_monitor.sv
// -----------------------------------------------------------------------------
// uvmt_cv32e40s_obi_stall_monitor
// Multi-channel OBI stall monitor; one independent channel per OBI port,
// channel c driving slice [c] of every output.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   obi_req_i/gnt_i/rvalid_i  per-channel OBI handshake signals
//   addr_ph_cnt_o         per-channel address-phase count (32 bits each)
//   rsp_ph_cnt_o          per-channel response-phase count (32 bits each)
//   outstanding_o         per-channel outstanding count (CNT_W each)
//   max_rsp_stalls_o      per-channel worst response stall (CNT_W each)
//   rsp_viol_o/gnt_viol_o per-channel violation pulses
//   err_sticky_o          per-channel {underflow, overflow, gnt_viol, rsp_viol}
// Optional: define UVMT_OBI_STALL_MONITOR_ASSERT_EN to bind concurrent
// assertions on violations, overflow and underflow for every channel.
// -----------------------------------------------------------------------------
`ifdef UVMT_OBI_STALL_MONITOR_ASSERT_EN
module uvmt_cv32e40s_obi_stall_checker #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 8
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  input logic [NUM_CH-1:0]       obi_req_i,
  input logic [NUM_CH-1:0]       obi_gnt_i,
  input logic [NUM_CH-1:0]       obi_rvalid_i,
  input logic [NUM_CH*CNT_W-1:0] outstanding_i,
  input logic [NUM_CH-1:0]       rsp_viol_i,
  input logic [NUM_CH-1:0]       gnt_viol_i
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
    a_rsp_viol : assert property (@(posedge clk_i) disable iff (!rst_ni) !rsp_viol_i[c])
      else $error("obi_stall_monitor ch%0d: response stall limit exceeded", c);
    a_gnt_viol : assert property (@(posedge clk_i) disable iff (!rst_ni) !gnt_viol_i[c])
      else $error("obi_stall_monitor ch%0d: grant stall limit exceeded", c);
    a_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(obi_req_i[c] && obi_gnt_i[c] && !obi_rvalid_i[c] &&
          (outstanding_i[c*CNT_W +: CNT_W] == CNT_W'(MAX_OUTSTANDING))))
      else $error("obi_stall_monitor ch%0d: outstanding overflow", c);
    a_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(obi_rvalid_i[c] && (outstanding_i[c*CNT_W +: CNT_W] == {CNT_W{1'b0}})))
      else $error("obi_stall_monitor ch%0d: outstanding underflow", c);
  end
endmodule : uvmt_cv32e40s_obi_stall_checker
`endif

module uvmt_cv32e40s_obi_stall_monitor
  import uvmt_cv32e40s_obi_stall_pkg::*;
#(
  parameter int unsigned NUM_CH          = DEF_NUM_CH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned MAX_RSP_STALLS  = DEF_MAX_RSP_STALLS,
  parameter int unsigned MAX_GNT_STALLS  = DEF_MAX_GNT_STALLS,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       obi_req_i,
  input  logic [NUM_CH-1:0]       obi_gnt_i,
  input  logic [NUM_CH-1:0]       obi_rvalid_i,
  output logic [NUM_CH*32-1:0]    addr_ph_cnt_o,
  output logic [NUM_CH*32-1:0]    rsp_ph_cnt_o,
  output logic [NUM_CH*CNT_W-1:0] outstanding_o,
  output logic [NUM_CH*CNT_W-1:0] max_rsp_stalls_o,
  output logic [NUM_CH-1:0]       rsp_viol_o,
  output logic [NUM_CH-1:0]       gnt_viol_o,
  output logic [NUM_CH*ERR_W-1:0] err_sticky_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    uvmt_cv32e40s_obi_stall_channel #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .MAX_RSP_STALLS  (MAX_RSP_STALLS),
      .MAX_GNT_STALLS  (MAX_GNT_STALLS),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_i            (obi_req_i[c]),
      .gnt_i            (obi_gnt_i[c]),
      .rvalid_i         (obi_rvalid_i[c]),
      .addr_ph_cnt_o    (addr_ph_cnt_o[c*32 +: 32]),
      .rsp_ph_cnt_o     (rsp_ph_cnt_o[c*32 +: 32]),
      .outstanding_o    (outstanding_o[c*CNT_W +: CNT_W]),
      .max_rsp_stalls_o (max_rsp_stalls_o[c*CNT_W +: CNT_W]),
      .rsp_viol_o       (rsp_viol_o[c]),
      .gnt_viol_o       (gnt_viol_o[c]),
      .err_sticky_o     (err_sticky_o[c*ERR_W +: ERR_W])
    );
  end

`ifdef UVMT_OBI_STALL_MONITOR_ASSERT_EN
  uvmt_cv32e40s_obi_stall_checker #(
    .NUM_CH          (NUM_CH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .obi_req_i     (obi_req_i),
    .obi_gnt_i     (obi_gnt_i),
    .obi_rvalid_i  (obi_rvalid_i),
    .outstanding_i (outstanding_o),
    .rsp_viol_i    (rsp_viol_o),
    .gnt_viol_i    (gnt_viol_o)
  );
`endif

endmodule : uvmt_cv32e40s_obi_stall_monitor
